// File: rtl/circuito_jogo_param.sv
// Memory-sequence game core: plays back a stored move sequence on the LEDs,
// checks the player's repetition and grows the sequence by one move per round.
module circuito_jogo_param #(
    parameter int N_CHAVES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int MOSTRA_CICLOS  = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo,
    input  logic [N_CHAVES-1:0] chaves,
    output logic [N_CHAVES-1:0] leds,
    output logic                ganhou,
    output logic                perdeu,
    output logic                pronto,
    output logic [3:0]          db_estado,
    output logic [5:0]          db_rodada,
    output logic [5:0]          db_endereco,
    output logic [N_CHAVES-1:0] db_jogada,
    output logic                db_grava,
    output logic                db_timeout
);

    localparam int AW      = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
    localparam int CNT_MAX = (TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA_LIGA    = 4'h2,
        MOSTRA_DESLIGA = 4'h3,
        ESPERA_JOGADA  = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        FIM_RODADA     = 4'h7,
        ESPERA_ESCRITA = 4'h8,
        ESCREVE        = 4'h9,
        FIM_GANHOU     = 4'hA,
        FIM_PERDEU     = 4'hE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [5:0]          rodada_q, rodada_d;
    logic [5:0]          endereco_q, endereco_d;
    logic                modo_q, modo_d;
    logic                tout_q, tout_d;
    logic [N_CHAVES-1:0] jogada_q, jogada_d;
    logic                tecla_q;
    logic [15:0]         lfsr_q;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [N_CHAVES-1:0] mem_q [MAX_RODADAS];
    logic [N_CHAVES-1:0] rdata, wdata, move;
    logic [5:0]          waddr;
    logic                grava;
    logic [3:0]          mv_idx;
    logic                jogada, fim_mostra, timeout_hit, fim_seq;

    assign jogada      = (|chaves) & ~tecla_q;
    assign mv_idx      = 4'({29'd0, lfsr_q[2:0]} % N_CHAVES);
    assign move        = {{(N_CHAVES-1){1'b0}}, 1'b1} << mv_idx;
    assign rdata       = mem_q[endereco_q[AW-1:0]];
    assign fim_mostra  = (cnt_q == CW'(MOSTRA_CICLOS - 1));
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CICLOS - 1));
    assign fim_seq     = (endereco_q == rodada_q);

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        modo_d     = modo_q;
        tout_d     = tout_q;
        jogada_d   = jogada_q;
        leds       = '0;
        grava      = 1'b0;
        waddr      = rodada_q + 6'd1;
        wdata      = move;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARACAO;
            PREPARACAO: begin
                rodada_d   = '0;
                endereco_d = '0;
                tout_d     = 1'b0;
                modo_d     = modo;
                grava      = 1'b1;
                waddr      = '0;
                estado_d   = MOSTRA_LIGA;
            end
            MOSTRA_LIGA: begin
                leds = rdata;
                if (fim_mostra) estado_d = MOSTRA_DESLIGA;
            end
            MOSTRA_DESLIGA: if (fim_mostra) begin
                if (fim_seq) begin
                    endereco_d = '0;
                    estado_d   = ESPERA_JOGADA;
                end else begin
                    endereco_d = endereco_q + 6'd1;
                    estado_d   = MOSTRA_LIGA;
                end
            end
            ESPERA_JOGADA, ESPERA_ESCRITA: begin
                // A key press in the last counted cycle beats the timeout.
                if (jogada) begin
                    jogada_d = chaves;
                    estado_d = (estado_q == ESPERA_JOGADA) ? COMPARA : ESCREVE;
                end else if (timeout_hit) begin
                    tout_d   = 1'b1;
                    estado_d = FIM_PERDEU;
                end
            end
            COMPARA: begin
                if (jogada_q != rdata) estado_d = FIM_PERDEU;
                else if (fim_seq)      estado_d = FIM_RODADA;
                else                   estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: begin
                endereco_d = endereco_q + 6'd1;
                estado_d   = ESPERA_JOGADA;
            end
            FIM_RODADA: begin
                if (rodada_q == 6'(MAX_RODADAS - 1)) begin
                    estado_d = FIM_GANHOU;
                end else if (!modo_q) begin
                    grava      = 1'b1;
                    rodada_d   = rodada_q + 6'd1;
                    endereco_d = '0;
                    estado_d   = MOSTRA_LIGA;
                end else begin
                    estado_d = ESPERA_ESCRITA;
                end
            end
            ESCREVE: begin
                grava      = 1'b1;
                wdata      = jogada_q;
                rodada_d   = rodada_q + 6'd1;
                endereco_d = '0;
                estado_d   = MOSTRA_LIGA;
            end
            FIM_GANHOU, FIM_PERDEU: if (iniciar) estado_d = PREPARACAO;
            default: estado_d = INICIAL;
        endcase
        // One counter serves both display phases and entry timeout; restarts on any state change.
        cnt_d = (estado_d != estado_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            rodada_q   <= '0;
            endereco_q <= '0;
            modo_q     <= 1'b0;
            tout_q     <= 1'b0;
            jogada_q   <= '0;
            tecla_q    <= 1'b0;
            lfsr_q     <= 16'hACE1;
            cnt_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            modo_q     <= modo_d;
            tout_q     <= tout_d;
            jogada_q   <= jogada_d;
            tecla_q    <= |chaves;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (grava) mem_q[waddr[AW-1:0]] <= wdata;
    end

    assign ganhou      = (estado_q == FIM_GANHOU);
    assign perdeu      = (estado_q == FIM_PERDEU);
    assign pronto      = ganhou | perdeu;
    assign db_estado   = estado_q;
    assign db_rodada   = rodada_q;
    assign db_endereco = endereco_q;
    assign db_jogada   = jogada_q;
    assign db_grava    = grava;
    assign db_timeout  = tout_q;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param: a per-vector table for round-0 entry
// outcomes plus hand sequences for win, late loss, player append and async reset.
module tb_circuito_jogo_param;

    localparam int N = 4, MAXR = 4, TOUT = 20, MOS = 3;

    logic       clock = 1'b0, reset = 1'b0, iniciar = 1'b0, modo = 1'b0;
    logic [3:0] chaves = '0;
    logic [3:0] leds, db_estado, db_jogada;
    logic [5:0] db_rodada, db_endereco;
    logic       ganhou, perdeu, pronto, db_grava, db_timeout;

    circuito_jogo_param #(.N_CHAVES(N), .MAX_RODADAS(MAXR), .TIMEOUT_CICLOS(TOUT), .MOSTRA_CICLOS(MOS)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .chaves(chaves),
        .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_endereco(db_endereco),
        .db_jogada(db_jogada), .db_grava(db_grava), .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    logic [15:0] lfsr_m;
    always @(posedge clock or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    logic [3:0] exp_mem [MAXR];
    int n_tests = 0, n_fail = 0;

    typedef struct {
        int         kind;       // 0 correct, 1 wrong one-hot, 2 multi-bit, 3 no key, 4 correct on last cycle
        logic [3:0] exp_state;
        logic       exp_tout;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [3:0] mv(input logic [15:0] l);
        int i;
        i = int'(l[2:0]) % N;
        return 4'(1 << i);
    endfunction

    function automatic logic [3:0] rot(input logic [3:0] k);
        return {k[2:0], k[3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (db_estado !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, db_estado, s);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start(input logic m);
        iniciar = 1'b1;
        modo    = m;
        @(negedge clock);
        iniciar = 1'b0;
        check("start_state", db_estado, 4'h1);
        check("start_grava", db_grava, 1'b1);
        check("start_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0000);
        exp_mem[0] = mv(lfsr_m);
    endtask

    task automatic playback(input int r);
        int bad = 0;
        wait_state(4'h2, 10, $sformatf("play_r%0d_begin", r));
        for (int a = 0; a <= r; a++) begin
            for (int k = 0; k < MOS; k++) begin
                if (leds !== exp_mem[a] || db_estado !== 4'h2) bad++;
                @(negedge clock);
            end
            for (int k = 0; k < MOS; k++) begin
                if (leds !== 4'h0 || db_estado !== 4'h3) bad++;
                @(negedge clock);
            end
        end
        check($sformatf("play_r%0d_leds", r), bad, 0);
        check($sformatf("play_r%0d_end", r), db_estado, 4'h4);
    endtask

    task automatic play_round(input int r);
        playback(r);
        for (int a = 0; a <= r; a++) begin
            chaves = exp_mem[a];
            @(negedge clock);
            check("answer_cmp", db_estado, 4'h5);
            chaves = '0;
            @(negedge clock);
            if (a < r) begin
                check("answer_next", db_estado, 4'h6);
                @(negedge clock);
            end else begin
                check("answer_fim", db_estado, 4'h7);
            end
        end
    endtask

    initial begin
        logic [3:0] key;
        vecs[0] = '{0, 4'h7, 1'b0};
        vecs[1] = '{1, 4'hE, 1'b0};
        vecs[2] = '{2, 4'hE, 1'b0};
        vecs[3] = '{3, 4'hE, 1'b1};
        vecs[4] = '{4, 4'h7, 1'b0};

        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_state", db_estado, 4'h0);
        check("rst_outs", {leds, ganhou, perdeu, pronto, db_grava, db_timeout}, 9'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_state", db_estado, 4'h0);

        // Round-0 entry outcomes
        for (int v = 0; v < 5; v++) begin
            do_reset();
            start(1'b0);
            playback(0);
            key = exp_mem[0];
            if (vecs[v].kind == 1) key = rot(exp_mem[0]);
            if (vecs[v].kind == 2) key = exp_mem[0] | rot(exp_mem[0]);
            if (vecs[v].kind >= 3) begin
                repeat (TOUT - 1) @(negedge clock);
                check($sformatf("v%0d_still_wait", v), db_estado, 4'h4);
            end
            if (vecs[v].kind != 3) begin
                chaves = key;
                @(negedge clock);
                check($sformatf("v%0d_cmp", v), db_estado, 4'h5);
                check($sformatf("v%0d_jogada", v), db_jogada, key);
                chaves = '0;
            end
            @(negedge clock);
            check($sformatf("v%0d_state", v), db_estado, vecs[v].exp_state);
            check($sformatf("v%0d_tout", v), db_timeout, vecs[v].exp_tout);
            check($sformatf("v%0d_perdeu", v), perdeu, vecs[v].exp_state == 4'hE);
        end

        // Full win in automatic mode
        do_reset();
        start(1'b0);
        for (int r = 0; r < MAXR; r++) begin
            play_round(r);
            if (r < MAXR - 1) begin
                check("append_grava", db_grava, 1'b1);
                exp_mem[r+1] = mv(lfsr_m);
                @(negedge clock);
            end else begin
                check("last_grava", db_grava, 1'b0);
                @(negedge clock);
            end
        end
        check("win_state", db_estado, 4'hA);
        check("win_flags", {ganhou, perdeu, pronto}, 3'b101);
        check("win_rodada", db_rodada, 6'd3);

        // Wrong key at round 1 address 1, then restart clears flags
        start(1'b0);
        play_round(0);
        exp_mem[1] = mv(lfsr_m);
        @(negedge clock);
        playback(1);
        chaves = exp_mem[0];
        @(negedge clock);
        chaves = '0;
        @(negedge clock);
        check("r1_next", db_estado, 4'h6);
        @(negedge clock);
        check("r1_wait", db_estado, 4'h4);
        chaves = rot(exp_mem[1]);
        @(negedge clock);
        chaves = '0;
        @(negedge clock);
        check("lose_state", db_estado, 4'hE);
        check("lose_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0110);
        start(1'b0);

        // Asynchronous reset during playback
        @(negedge clock);
        check("pre_rst_state", db_estado, 4'h2);
        check("pre_rst_leds", leds, exp_mem[0]);
        #1 reset = 1'b1;
        #1;
        check("async_rst_state", db_estado, 4'h0);
        check("async_rst_leds", leds, 4'h0);
        @(negedge clock);
        reset = 1'b0;

        // Player-append mode
        start(1'b1);
        play_round(0);
        @(negedge clock);
        check("m1_wait_wr", db_estado, 4'h8);
        chaves = 4'b0100;
        @(negedge clock);
        check("m1_escreve", db_estado, 4'h9);
        check("m1_grava", db_grava, 1'b1);
        chaves = '0;
        exp_mem[1] = 4'b0100;
        @(negedge clock);
        check("m1_rodada", db_rodada, 6'd1);
        playback(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/circuito_jogo_param.md
Name: circuito_jogo_param

Overview:
- Parametrised successor of the memory-sequence game core. Control FSM, counters, sequence RAM, LFSR move generator and timeout timer live in one block.
- Each round the block plays back the whole stored sequence on the LEDs, then checks the player's repetition.
- On success it appends a new move: random in mode 0, player-entered in mode 1.
- It sits under the board top level, which does the 7-segment decoding of the raw debug outputs.

Parameters:
- N_CHAVES, 4, number of keys/LEDs (2..8).
- MAX_RODADAS, 16, sequence length needed to win (2..64).
- TIMEOUT_CICLOS, 5000, cycles allowed per move entry.
- MOSTRA_CICLOS, 1000, LED on-time and off-time per played-back move.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  start/restart request
- modo  in  1  0 = automatic append, 1 = player append; sampled when iniciar is accepted
- chaves  in  N_CHAVES  player keys
- leds  out  N_CHAVES  playback display
- ganhou  out  1  win flag
- perdeu  out  1  lose flag
- pronto  out  1  game finished
- db_estado  out  4  FSM state code
- db_rodada  out  6  current round index
- db_endereco  out  6  current sequence address
- db_jogada  out  N_CHAVES  last registered key value
- db_grava  out  1  RAM write strobe
- db_timeout  out  1  the loss was caused by timeout

Behaviour:
- Reset (async, active-high): state 0, all counters 0, LFSR = 16'hACE1, all outputs 0, modo register 0. RAM contents are not cleared.
- LFSR:
  - Fibonacci, 16 bits, shifts left every clock in every state. New bit = q[15]^q[13]^q[12]^q[10].
  - Move = one-hot with bit index (lfsr[2:0] mod N_CHAVES).
- Key detection:
  - jogada = |chaves high this cycle and low the previous cycle.
  - On a detection, db_jogada <= chaves.
  - Detection is acted on only in states 4 and 8; it is ignored elsewhere.
- Timer:
  - Cleared on entry to state 4 or 8; counts every cycle while in either state.
  - Timeout fires when the count reaches TIMEOUT_CICLOS-1 with no jogada.
  - If jogada and timeout occur in the same cycle, jogada wins.
- States (db_estado code):
  - 0 inicial: all outputs 0. iniciar -> 1.
  - 1 preparacao: rodada=0, endereco=0, clear flags, latch modo. Write mem[0] = LFSR move; db_grava=1 for one cycle. -> 2.
  - 2 mostra_liga: leds = mem[endereco] for MOSTRA_CICLOS cycles. -> 3.
  - 3 mostra_desliga: leds = 0 for MOSTRA_CICLOS cycles. If endereco == rodada: endereco=0 -> 4. Otherwise endereco++ -> 2.
  - 4 espera_jogada: leds = 0. jogada -> 5. Timeout -> E with db_timeout=1.
  - 5 compara: if db_jogada != mem[endereco] -> E. Else if endereco == rodada -> 7. Else -> 6.
  - 6 proxima_jogada: endereco++ -> 4.
  - 7 fim_rodada:
    - rodada == MAX_RODADAS-1 -> A.
    - Else, modo 0: write mem[rodada+1] = LFSR move (db_grava=1), rodada++, endereco=0 -> 2.
    - Else, modo 1: -> 8.
  - 8 espera_escrita: jogada -> 9. Timeout -> E with db_timeout=1.
  - 9 escreve: write mem[rodada+1] = db_jogada (db_grava=1), rodada++, endereco=0 -> 2.
  - A fim_ganhou: ganhou=1, pronto=1, held. iniciar -> 1.
  - E fim_perdeu: perdeu=1, pronto=1, held. iniciar -> 1.
- iniciar is ignored outside states 0, A and E.
- Flags ganhou, perdeu and db_timeout are cleared in state 1.
- Playback of round r takes exactly 2*MOSTRA_CICLOS*(r+1) cycles.
- Unused codes (B, C, D, F) -> 0.
- Reset mid-game returns to state 0 immediately (asynchronously).
- A multi-bit key press is compared and stored as-is.

Test Plan:
Default setup: N_CHAVES=4, MAX_RODADAS=4, TIMEOUT_CICLOS=20, MOSTRA_CICLOS=3.
- Reset pulse -> db_estado=0, leds=0, ganhou=perdeu=pronto=0, db_grava=0. Model LFSR matches from seed 16'hACE1.
- modo=0, iniciar; answer each round with the played-back moves -> rounds 0..3 play 6/12/18/24 lit/dark cycles; finally db_estado=A, ganhou=1, pronto=1, perdeu=0.
- modo=0, wrong key at round 1 address 1 -> db_estado=E, perdeu=1, pronto=1, db_timeout=0. A following iniciar -> state 1, flags cleared.
- No key for 20 cycles in state 4 -> db_estado=E, perdeu=1, db_timeout=1. Key pressed on exactly the 20th cycle -> goes to 5, no timeout.
- modo=1, pass round 0, press 4'b0100 in state 8 -> db_grava pulse, db_rodada=1; playback shows mem[0] then 0100.
- Assert reset during state 2 -> db_estado=0 and leds=0 before the next clock edge.
